// File: rtl/masked_inv_sbox_pkg.sv
// masked_inv_sbox_pkg: shared constants, share type and GF(2^8) helpers for the masked inverse S-box
package masked_inv_sbox_pkg;
  localparam int SHARE_W = 8;
  localparam logic [SHARE_W-1:0] INV_AFF_C = 8'h05;
  localparam int LAT = 6;
  localparam int LAT_OUT_REG = 7;
  localparam int R0_LSB = 0;
  localparam int R1_LSB = 8;
  localparam int KR_LSB = 16;
  typedef struct packed {
    logic [SHARE_W-1:0] sh1;
    logic [SHARE_W-1:0] sh0;
  } shares_t;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 by square-and-multiply; zero maps to zero
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2 = gf_mul(x, x);
    x3 = gf_mul(x2, x);
    x12 = gf_mul(x3, x3);
    x12 = gf_mul(x12, x12);
    x15 = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction
  function automatic logic [7:0] r0_map(input logic [7:0] r);
    return (r == 8'h00) ? 8'h01 : r;
  endfunction
endpackage

// File: rtl/masked_inv_sbox_inv_linear_mapping.sv
// inv_linear_mapping: linear part of the AES inverse affine map (rotl 1 ^ rotl 3 ^ rotl 6)
module inv_linear_mapping (
  input  logic [7:0] x,
  output logic [7:0] y
);
  assign y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
endmodule

// File: rtl/masked_inv_sbox.sv
// masked_inv_sbox: first-order multiplicatively masked AES inverse S-box, 6-stage pipeline (7 with MASKED_INV_SBOX_OUT_REG_EN)
module masked_inv_sbox
  import masked_inv_sbox_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [19:0] PRNG,
  input  logic [15:0] inp,
  output logic        out_valid,
  output logic [15:0] SB_out,
  output logic        busy
);
  logic [7:0] l1, l0, n1, n0, r0, r1, b1, b0, pinv, p0;
  logic [3:0] z, e1, o1, e0, o0, k1_11, k1_10, k1_01, k1_00, c1_1, c1_0;
  logic [1:0] k2_11, k2_10, k2_01, k2_00, c2_1, c2_0, dd5, dd6;
  logic       k3_11, k3_10, k3_01, k3_00, d1, d0;
  shares_t    a_q1, a_q2, a_q3, a_q4, pr, yp, y_comb;
  logic [5:0] vld;
  logic [2:0] cnt;
  inv_linear_mapping u_lm1 (.x(inp[15:8]), .y(l1));
  inv_linear_mapping u_lm0 (.x(inp[7:0]),  .y(l0));
  assign r0 = r0_map(PRNG[R0_LSB +: 8]);
  assign r1 = PRNG[R1_LSB +: 8];
  assign z = PRNG[KR_LSB +: 4];
  // Kronecker delta as a DOM AND tree over the shared bits of ~a
  assign n1 = ~a_q1.sh1;
  assign n0 = a_q1.sh0;
  assign e1 = {n1[6], n1[4], n1[2], n1[0]};
  assign o1 = {n1[7], n1[5], n1[3], n1[1]};
  assign e0 = {n0[6], n0[4], n0[2], n0[0]};
  assign o0 = {n0[7], n0[5], n0[3], n0[1]};
  assign c1_1 = k1_11 ^ k1_10;
  assign c1_0 = k1_00 ^ k1_01;
  assign c2_1 = k2_11 ^ k2_10;
  assign c2_0 = k2_00 ^ k2_01;
  assign d1 = k3_11 ^ k3_10;
  assign d0 = k3_00 ^ k3_01;
  assign b1 = a_q4.sh1 ^ {7'b0, d1};
  assign b0 = a_q4.sh0 ^ {7'b0, d0};
  assign pinv = gf_inv(pr.sh1 ^ pr.sh0);
  assign y_comb = {yp.sh1 ^ {7'b0, dd6[1]}, yp.sh0 ^ {7'b0, dd6[0]}};
  assign busy = (cnt != 3'd0);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q1 <= '0;
      a_q2 <= '0;
      a_q3 <= '0;
      a_q4 <= '0;
      k1_11 <= '0;
      k1_10 <= '0;
      k1_01 <= '0;
      k1_00 <= '0;
      k2_11 <= '0;
      k2_10 <= '0;
      k2_01 <= '0;
      k2_00 <= '0;
      k3_11 <= 1'b0;
      k3_10 <= 1'b0;
      k3_01 <= 1'b0;
      k3_00 <= 1'b0;
      pr <= '0;
      p0 <= '0;
      dd5 <= '0;
      dd6 <= '0;
      yp <= '0;
      vld <= '0;
      cnt <= '0;
    end else begin
      a_q1 <= {l1 ^ INV_AFF_C, l0};
      a_q2 <= a_q1;
      a_q3 <= a_q2;
      a_q4 <= a_q3;
      k1_11 <= e1 & o1;
      k1_10 <= (e1 & o0) ^ z;
      k1_01 <= (e0 & o1) ^ z;
      k1_00 <= e0 & o0;
      k2_11 <= {c1_1[2], c1_1[0]} & {c1_1[3], c1_1[1]};
      k2_10 <= ({c1_1[2], c1_1[0]} & {c1_0[3], c1_0[1]}) ^ z[1:0];
      k2_01 <= ({c1_0[2], c1_0[0]} & {c1_1[3], c1_1[1]}) ^ z[1:0];
      k2_00 <= {c1_0[2], c1_0[0]} & {c1_0[3], c1_0[1]};
      k3_11 <= c2_1[0] & c2_1[1];
      k3_10 <= (c2_1[0] & c2_0[1]) ^ z[0];
      k3_01 <= (c2_0[0] & c2_1[1]) ^ z[0];
      k3_00 <= c2_0[0] & c2_0[1];
      pr <= {gf_mul(r0, b1), gf_mul(r0, b0)};
      p0 <= r0;
      dd5 <= {d1, d0};
      yp <= {gf_mul(p0, pinv ^ r1), gf_mul(p0, r1)};
      dd6 <= dd5;
      vld <= {vld[4:0], in_valid};
      cnt <= (in_valid && !out_valid) ? cnt + 3'd1 :
             (!in_valid && out_valid) ? cnt - 3'd1 : cnt;
    end
  end
`ifdef MASKED_INV_SBOX_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      SB_out <= '0;
    end else begin
      out_valid <= vld[5];
      SB_out <= y_comb;
    end
  end
`else
  assign out_valid = vld[5];
  assign SB_out = y_comb;
`endif
endmodule

// File: tb/tb_masked_inv_sbox.sv
// tb_masked_inv_sbox: scoreboard bench for masked_inv_sbox against a forward-derived InvSbox table
module tb_masked_inv_sbox;
  import masked_inv_sbox_pkg::*;
`ifdef MASKED_INV_SBOX_OUT_REG_EN
  localparam int LAT_X = LAT_OUT_REG;
`else
  localparam int LAT_X = LAT;
`endif
  typedef struct {
    logic [7:0] v;
    int         c;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] PRNG = '0;
  logic [15:0] inp = '0;
  logic        out_valid, busy;
  logic [15:0] SB_out;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mc = 0;
  logic [7:0]  inv_tab [256];
  masked_inv_sbox dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .PRNG(PRNG), .inp(inp),
    .out_valid(out_valid), .SB_out(SB_out), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    return 8'((x << k) | (x >> (8 - k)));
  endfunction
  function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] iv;
    iv = 8'h00;
    for (int i = 1; i < 256; i++) if (bmul(b, 8'(i)) == 8'h01) iv = 8'(i);
    return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] val, input logic [7:0] exp, input logic [7:0] x0);
    @(posedge clk);
    #1;
    in_valid = v;
    PRNG = 20'($urandom);
    inp = {val ^ x0, x0};
    if (v && !rst) q.push_back('{exp, cyc});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'h00, 8'($urandom));
  endtask
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy", 16'(busy), 16'(mc != 0));
      if (out_valid) begin
        if (q.size() == 0) check("spurious_valid", 16'd1, 16'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("data", 16'(SB_out[15:8] ^ SB_out[7:0]), 16'(e.v));
          check("latency", 16'(cyc - e.c), 16'(LAT_X));
        end
      end
      mc = rst ? 0 : mc + int'(in_valid) - int'(out_valid);
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    for (int b = 0; b < 256; b++) inv_tab[sbox(8'(b))] = 8'(b);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_out", SB_out, 16'h0000);
    rst = 1'b0;
    step(1'b1, 8'h00, 8'h52, 8'h5A);
    idle(10);
    step(1'b1, 8'h63, 8'h00, 8'($urandom));
    step(1'b1, 8'h7C, 8'h01, 8'($urandom));
    step(1'b1, 8'h16, 8'hFF, 8'($urandom));
    idle(10);
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), inv_tab[i], 8'($urandom));
    idle(10);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'h00, 8'($urandom));
    idle(1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("post_rst_busy", 16'(busy), 16'd0);
    check("post_rst_out", SB_out, 16'h0000);
    check("post_rst_valid", 16'(out_valid), 16'd0);
    idle(12);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      step(1'(i % 2 == 0), v, inv_tab[v], 8'($urandom));
    end
    idle(2);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    check("drain", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
